// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch (I) and memory-stage (D) ports.
// Each access is a req/ack transaction with an optional timeout and a round-robin grant on conflicts.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [XLEN-1:0]       i_rdata,
  output logic                  i_ready,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [XLEN-1:0]       d_wdata,
  output logic [XLEN-1:0]       d_rdata,
  output logic                  d_ready,

  output logic                  stall_i,
  output logic                  stall_d,

  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_ack,
  input  logic [XLEN-1:0]       mem_rdata,

  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t           state;
  logic             last_d;     // 1: most recent grant went to D
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             i_elig;
  logic             d_elig;
  logic             grant_i;
  logic             grant_d;
  logic             timeout_hit;

  // A port whose ready pulse is high this cycle is being retired, so it must not be regranted.
  always_comb begin
    i_elig      = i_req & ~i_ready;
    d_elig      = d_req & ~d_ready;
    grant_d     = d_elig & (~i_elig | ~last_d);
    grant_i     = i_elig & ~grant_d;
    cnt_inc     = (&cnt) ? cnt : cnt + CNT_W'(1);
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
  end

  assign stall_i = i_req & ~i_ready;
  assign stall_d = d_req & ~d_ready;

  // NOTE: every register here uses <= so all updates see the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      cnt         <= '0;
      i_rdata     <= '0;
      i_ready     <= 1'b0;
      d_rdata     <= '0;
      d_ready     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            last_d    <= 1'b1;
            cnt       <= '0;
            state     <= BUSY_D;
          end else if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            last_d    <= 1'b0;
            cnt       <= '0;
            state     <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ack || timeout_hit) begin
            // A real ack wins over a timeout landing in the same cycle.
            mem_req <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
            if (!mem_ack) timeout_err <= 1'b1;
            if (state == BUSY_I) begin
              i_ready <= 1'b1;
              i_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              d_ready <= 1'b1;
              if (!mem_we) d_rdata <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and read data are queued by the
// directed stimulus and consumed by monitors that watch mem_req rising and the ready pulses.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ready, d_ready, stall_i, stall_d;
  logic        mem_req, mem_we, mem_ack, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  grant_t      gq[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  int          compared = 0;
  int          mismatched = 0;
  int          ack_wait = 0;    // mem_req cycles before ack; negative = never
  logic [31:0] rd = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_i(stall_i), .stall_d(stall_d),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_wait mem_req cycles with the current rd value.
  initial begin
    int waited = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !mem_ack) begin
        if (ack_wait >= 0 && waited == ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
        waited++;
      end else begin
        mem_ack = 1'b0;
        waited  = 0;
      end
    end
  end

  // Grant monitor.
  initial begin
    logic   prev_req = 1'b0;
    grant_t g;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (gq.size() == 0) check("unexpected_grant", 1, 0);
        else begin
          g = gq.pop_front();
          check("grant_addr", mem_addr, g.addr);
          check("grant_we", mem_we, g.we);
          if (g.we) check("grant_wdata", mem_wdata, g.wdata);
        end
      end
      prev_req = mem_req;
    end
  end

  // Ready/response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (i_ready) begin
        check("i_ready_overlap", mem_req, 0);
        if (iq.size() == 0) check("i_ready_unexpected", 1, 0);
        else check("i_rdata", i_rdata, iq.pop_front());
      end
      if (d_ready) begin
        check("d_ready_overlap", mem_req, 0);
        if (dq.size() == 0) check("d_ready_unexpected", 1, 0);
        else check("d_rdata", d_rdata, dq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int req_cycles);
    bit seen = 0;
    bit stall_ok = 1;
    d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    req_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (d_ready) begin
        seen = 1;
        check("stall_d_at_ready", stall_d, 0);
        break;
      end
      if (!stall_d) stall_ok = 0;
    end
    check("d_ready_seen", seen, 1);
    check("stall_d_until_ready", stall_ok, 1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic i_txn(input logic [31:0] addr, output int req_cycles);
    bit seen = 0;
    bit stall_ok = 1;
    i_addr = addr; i_req = 1'b1;
    req_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (i_ready) begin
        seen = 1;
        check("stall_i_at_ready", stall_i, 0);
        break;
      end
      if (!stall_i) stall_ok = 0;
    end
    check("i_ready_seen", seen, 1);
    check("stall_i_until_ready", stall_ok, 1);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int dc, ic;
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; d_wdata = '0;

    // Reset held 3 cycles with d_req pending.
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_stall_d", stall_d, 1);
    check("rst_stall_i", stall_i, 0);

    ack_wait = 0; rd = 32'h1111_1111;
    gq.push_back('{we: 1'b0, addr: 32'h8, wdata: 32'h0});
    dq.push_back(32'h1111_1111);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mem_req_first_cycle_after_reset", mem_req, 0);
    d_txn(1'b0, 32'h8, 32'h0, dc);
    check("d_first_req_cycles", dc, 1);
    idle(2);

    // Single I read, ack on the second mem_req cycle.
    ack_wait = 1; rd = 32'hDEAD_BEEF;
    gq.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
    iq.push_back(32'hDEAD_BEEF);
    i_txn(32'h40, ic);
    check("i_read_req_cycles", ic, 2);
    idle(3);
    check("i_rdata_held", i_rdata, 32'hDEAD_BEEF);
    check("i_ready_low_after", i_ready, 0);
    check("stall_i_idle", stall_i, 0);

    // Fresh reset, then a conflict: D wins the first one.
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    ack_wait = 0; rd = 32'hCAFE_0001;
    gq.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'h55});
    gq.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0});
    dq.push_back(32'h0);
    iq.push_back(32'hCAFE_0001);
    fork
      d_txn(1'b1, 32'h100, 32'h55, dc);
      i_txn(32'h80, ic);
    join
    idle(2);

    // D load to establish d_rdata.
    rd = 32'h1234;
    gq.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    dq.push_back(32'h1234);
    d_txn(1'b0, 32'h200, 32'h0, dc);
    idle(2);

    // Second conflict after a D grant: I goes first; the D store keeps d_rdata.
    rd = 32'hA5A5_A5A5;
    gq.push_back('{we: 1'b0, addr: 32'h84, wdata: 32'h0});
    gq.push_back('{we: 1'b1, addr: 32'h104, wdata: 32'h77});
    iq.push_back(32'hA5A5_A5A5);
    dq.push_back(32'h1234);
    fork
      d_txn(1'b1, 32'h104, 32'h77, dc);
      i_txn(32'h84, ic);
    join
    idle(2);
    check("d_rdata_after_store", d_rdata, 32'h1234);

    // Load that memory never acknowledges: timeout after 4 wait cycles.
    ack_wait = -1;
    gq.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    dq.push_back(32'h0);
    check("timeout_err_before", timeout_err, 0);
    d_txn(1'b0, 32'h300, 32'h0, dc);
    check("timeout_req_cycles", dc, 4);
    idle(3);
    check("timeout_err_sticky", timeout_err, 1);
    check("i_rdata_unaffected", i_rdata, 32'hA5A5_A5A5);

    // Reset arrives in the same cycle as mem_ack while BUSY_D.
    ack_wait = 0; rd = 32'h999;
    gq.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0});
    d_we = 1'b0; d_addr = 32'h400; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_reset", mem_req, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("midrst_d_ready", d_ready, 0);
    check("midrst_d_rdata", d_rdata, 0);
    check("midrst_mem_req", mem_req, 0);
    check("midrst_timeout_err", timeout_err, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_midrst", mem_req, 0);

    check("grant_queue_drained", gq.size(), 0);
    check("i_queue_drained", iq.size(), 0);
    check("d_queue_drained", dq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (I-port, read-only) and the memory stage (D-port, load/store) of the 5-stage pipeline.
- Sequences each access as a multi-cycle req/ack transaction on the memory side.
- Returns per-port ready pulses and stall requests to the hazard logic.
- Raises a sticky error if memory fails to acknowledge.

Parameters:
XLEN, 32, data width of all data buses
ADDR_WIDTH, 32, width of all address buses
TIMEOUT, 255, maximum cycles waiting for mem_ack; 0 disables timeout
CNT_W, 8, width of timeout counter; must satisfy TIMEOUT < 2**CNT_W

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
i_req  in  1  fetch read request; held until i_ready
i_addr  in  ADDR_WIDTH  fetch address
i_rdata  out  XLEN  fetch read data; valid with i_ready and held afterwards
i_ready  out  1  one-cycle completion pulse for I-port
d_req  in  1  data request; held until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  XLEN  store data
d_rdata  out  XLEN  load data; valid with d_ready and held afterwards
d_ready  out  1  one-cycle completion pulse for D-port
stall_i  out  1  i_req & ~i_ready (combinational)
stall_d  out  1  d_req & ~d_ready (combinational)
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  XLEN  memory write data
mem_ack  in  1  memory completion; single-cycle
mem_rdata  in  XLEN  memory read data, valid when mem_ack=1
timeout_err  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset (reset=0 at clk edge):
  - Force FSM to IDLE.
  - Clear all outputs to 0, including i_rdata, d_rdata, mem_* and timeout_err.
  - Clear the wait counter; set last_grant=I.
  - Applies mid-transaction too: the outstanding access is abandoned and mem_ack is ignored while reset=0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE eligibility: a port is eligible if its req=1 and its ready is not 1 this cycle. This prevents regranting a request being retired this cycle.
- IDLE grant rule:
  - Both eligible: grant the port that is not last_grant (round-robin). The first conflict after reset goes to D.
  - One eligible: grant it.
  - None eligible: stay in IDLE.
- On grant:
  - Register addr/we/wdata into mem_addr/mem_we/mem_wdata. I-port grants force mem_we=0.
  - Set mem_req=1; update last_grant; go to BUSY_x.
- mem_* outputs change only on grant and on completion. Requester inputs are not sampled after the grant, so changes to them mid-transaction are ignored.
- BUSY_x, mem_ack=1:
  - Set mem_req=0 and clear the counter.
  - Pulse x_ready for exactly one cycle.
  - On reads, load x_rdata <= mem_rdata; on stores, d_rdata holds its value.
  - Return to IDLE.
- BUSY_x, mem_ack=0: increment the counter, saturating.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT, complete as above, with x_rdata <= 0 on reads, and set timeout_err=1.
- Latency: request sampled at edge N gives mem_req=1 after edge N. With mem_ack in the first mem_req cycle, ready=1 after edge N+1.
  - Minimum 2 cycles req-to-ready; 3 cycles between back-to-back grants to the same port.
- mem_ack while IDLE: ignored, no state change.
- If a requester drops req mid-transaction, the transaction still completes and the ready pulse still occurs.
- Only one transaction is outstanding at any time; mem_req never overlaps a ready pulse.

Test Plan:
- Reset held for 3 cycles with d_req=1 -> all outputs 0; first mem_req appears only 1 cycle after reset=1.
- i_req=1, i_addr=0x40; mem_ack after 2 cycles, mem_rdata=0xDEADBEEF -> mem_req high 2 cycles, mem_we=0, i_ready 1-cycle pulse, i_rdata=0xDEADBEEF held; stall_i high until pulse.
- i_req and d_req asserted together from reset, d_we=1, d_addr=0x100, d_wdata=0x55 -> D granted first (mem_we=1, mem_addr=0x100), then I; next conflict grants D only after I, confirming alternation.
- Store completes -> d_rdata keeps its previous load value 0x1234; d_req held high in ready cycle -> no duplicate grant.
- TIMEOUT=4, mem_ack never asserted on a load -> d_ready pulse after 4 wait cycles, d_rdata=0, timeout_err=1 until reset.
- reset=0 asserted while BUSY_D, mem_ack=1 in same cycle -> FSM in IDLE, d_ready=0, d_rdata=0, mem_req=0.
